// File: rtl/clock_set_ctrl_if.sv
// Panel/core bundle for clock_set_ctrl: raw keys and BCD time in, adjust/mode/blank/beep out.
// The master side is the front panel plus clock core; the controller is the slave.
interface clock_set_ctrl_if;
   logic       ModeKey;
   logic       IncKey;
   logic [7:0] Minute;
   logic [7:0] Second;
   logic       AdjHrKey;
   logic       AdjMinKey;
   logic [1:0] Mode;
   logic       HrBlank;
   logic       MinBlank;
   logic       Beep;

   modport master (
      output ModeKey, IncKey, Minute, Second,
      input  AdjHrKey, AdjMinKey, Mode, HrBlank, MinBlank, Beep
   );

   modport slave (
      input  ModeKey, IncKey, Minute, Second,
      output AdjHrKey, AdjMinKey, Mode, HrBlank, MinBlank, Beep
   );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-set controller: key debounce, RUN/SET_HR/SET_MIN machine, edit blink, idle timeout.
// Hourly chime sequencer is built only when CLOCK_SET_CHIME_EN is defined; otherwise Beep is 0.
module clock_set_ctrl #(
   parameter int DB_MS      = 20,
   parameter int TIMEOUT_MS = 10000,
   parameter int BLINK_MS   = 500,
   parameter int CHIME_MS   = 500
) (
   input  logic            _1kHzIn,
   input  logic            nCR,
   clock_set_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      SET_HR  = 2'b01,
      SET_MIN = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   localparam logic [7:0]  DB_LAST = 8'(DB_MS - 1);
   localparam logic [13:0] TO_LAST = 14'(TIMEOUT_MS - 1);
   localparam logic [8:0]  BL_LAST = 9'(BLINK_MS - 1);

   // Bit 0 is the mode key, bit 1 the increment key.
   logic [1:0] key_raw;
   logic [1:0] key_s1;
   logic [1:0] key_s2;
   logic [1:0] key_db;
   logic [1:0] key_db_q;
   logic [7:0] db_cnt [2];

   logic        mode_press;
   logic        inc_db;
   logic        inc_act;

   state_t      state;
   state_t      state_nx;
   logic [13:0] to_cnt;
   logic        to_exp;
   logic [8:0]  bl_cnt;
   logic        phase;

   assign key_raw = {bus.IncKey, bus.ModeKey};

   always_ff @(posedge _1kHzIn or negedge nCR) begin
      if (!nCR) begin
         key_s1   <= '0;
         key_s2   <= '0;
         key_db   <= '0;
         key_db_q <= '0;
         for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         key_s1   <= key_raw;
         key_s2   <= key_s1;
         key_db_q <= key_db;
         for (int unsigned i = 0; i < 2; i++) begin
            if (key_s2[i] == key_db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               key_db[i] <= key_s2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 8'd1;
            end
         end
      end
   end

   assign mode_press = key_db[0] & ~key_db_q[0];
   assign inc_db     = key_db[1];
   assign inc_act    = inc_db | (key_db[1] ^ key_db_q[1]);
   assign to_exp     = (to_cnt == TO_LAST);

   // Mode press takes priority over timeout expiry.
   always_comb begin
      state_nx = state;
      case (state)
         RUN:     if (mode_press) state_nx = SET_HR;
         SET_HR: begin
            if (mode_press)  state_nx = SET_MIN;
            else if (to_exp) state_nx = RUN;
         end
         SET_MIN: if (mode_press || to_exp) state_nx = RUN;
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge _1kHzIn or negedge nCR) begin
      if (!nCR) begin
         state  <= RUN;
         to_cnt <= '0;
         bl_cnt <= '0;
         phase  <= 1'b0;
      end else begin
         state <= state_nx;

         if (state == RUN || state_nx != state || mode_press || inc_act)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + 14'd1;

         if (state_nx != state) begin
            bl_cnt <= '0;
            phase  <= 1'b0;
         end else if (bl_cnt == BL_LAST) begin
            bl_cnt <= '0;
            phase  <= ~phase;
         end else begin
            bl_cnt <= bl_cnt + 9'd1;
         end
      end
   end

   assign bus.Mode      = state;
   assign bus.AdjHrKey  = (state == SET_HR)  & inc_db;
   assign bus.AdjMinKey = (state == SET_MIN) & inc_db;
   assign bus.HrBlank   = (state == SET_HR)  & phase & ~inc_db;
   assign bus.MinBlank  = (state == SET_MIN) & phase & ~inc_db;

`ifdef CLOCK_SET_CHIME_EN
   localparam logic [9:0] CH_LEN = 10'(CHIME_MS);

   logic       match;
   logic       m_s1;
   logic       m_s2;
   logic       m_q;
   logic [9:0] ch_cnt;

   assign match = ({bus.Minute, bus.Second} == 16'h5959);

   // A running pulse always completes; new triggers are accepted only when idle and in RUN.
   always_ff @(posedge _1kHzIn or negedge nCR) begin
      if (!nCR) begin
         m_s1   <= 1'b0;
         m_s2   <= 1'b0;
         m_q    <= 1'b0;
         ch_cnt <= '0;
      end else begin
         m_s1 <= match;
         m_s2 <= m_s1;
         m_q  <= m_s2;
         if (ch_cnt != '0)
            ch_cnt <= ch_cnt - 10'd1;
         else if (m_s2 && !m_q && state == RUN)
            ch_cnt <= CH_LEN;
      end
   end

   assign bus.Beep = (ch_cnt != '0);
`else
   logic unused_time;
   assign unused_time = ^{bus.Minute, bus.Second};
   assign bus.Beep    = 1'b0;
`endif

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-set and chime controller for the digital clock. It runs on the 1 kHz system clock and debounces the two front-panel keys. A three-state set-mode machine drives the `AdjHrKey`/`AdjMinKey` inputs of the clock core and generates display blanking for the field being edited. An optional hourly chime sequencer watches the clock's BCD `Minute`/`Second` outputs.

## Interface
Parameters:
- `DB_MS`, 20: debounce stability window, in `_1kHzIn` cycles (2..255).
- `TIMEOUT_MS`, 10000: idle cycles in a set state before returning to RUN (2..16383).
- `BLINK_MS`, 500: half-period of the edit-field blink, in cycles (2..511).
- `CHIME_MS`, 500: chime pulse length, in cycles (1..1023).

Ports:
- `_1kHzIn` in 1: system clock, rising edge.
- `nCR` in 1: reset, asynchronous, active-low.
- `ModeKey` in 1: raw mode key, active-high, asynchronous.
- `IncKey` in 1: raw increment key, active-high, asynchronous.
- `Minute` in 8: BCD minute from the clock core.
- `Second` in 8: BCD second from the clock core.
- `AdjHrKey` out 1: hour-adjust request to the clock core.
- `AdjMinKey` out 1: minute-adjust request to the clock core.
- `Mode` out 2: current state.
- `HrBlank` out 1: blank the hour digits.
- `MinBlank` out 1: blank the minute digits.
- `Beep` out 1: chime drive.

## Operation
- Key conditioning is identical for each key.
  - A 2-flop synchronizer feeds the debounce counter.
  - The counter clears whenever the synchronized value equals the debounced value `db`. Otherwise it increments.
  - When the counter reaches `DB_MS-1` while the values still differ, `db` takes the synchronized value and the counter clears.
- Key events:
  - A press is a rising edge of debounced `ModeKey`, detected against a registered copy.
  - Increment activity is any edge of debounced `IncKey`, or debounced `IncKey` being high.
- State machine, with `Mode` encoding RUN=00, SET_HR=01, SET_MIN=10.
  - A mode press moves RUN→SET_HR, SET_HR→SET_MIN and SET_MIN→RUN.
  - Timeout expiry in SET_HR or SET_MIN returns to RUN.
  - 11 is illegal and goes to RUN on the next cycle.
- Adjust outputs are combinational from state and the debounced increment key:
  - `AdjHrKey` = (Mode==SET_HR) & debounced `IncKey`.
  - `AdjMinKey` = (Mode==SET_MIN) & debounced `IncKey`.
  - The clock core then advances the field at its 1 Hz rate while the key is held.
- Idle timeout:
  - A 14-bit counter holds at 0 in RUN.
  - In a set state it clears on a mode press or increment activity. Otherwise it increments.
  - It expires when it reaches `TIMEOUT_MS-1`.
- Blink:
  - A counter runs from 0 to `BLINK_MS-1` and toggles `Phase` on wrap.
  - Entering any state clears both the counter and `Phase`.
  - `HrBlank` = SET_HR & `Phase` & ~debounced `IncKey`. `MinBlank` is the same with SET_MIN.
  - The edited field therefore stays lit while the increment key is held.
- Simultaneous events:
  - A mode press and timeout expiry in the same cycle: the mode press wins.
  - A mode press while the increment key is held: the state advances and the old field's adjust output drops that cycle.

## Timing
- Reset values: all outputs 0, `Mode`=RUN, all counters 0, `db`=0, synchronizers 0.
- Reset asserted mid-operation clears everything immediately.
- A raw key change held stable flips `db` at the (`DB_MS`+2)th rising edge after it is first sampled.
- A shorter glitch never reaches `db`.
- `Mode` updates one edge after the debounced mode key rises.
- `AdjHrKey`/`AdjMinKey` follow debounced `IncKey` with zero added latency.
- The timeout fires `TIMEOUT_MS` cycles after the last activity.
- Blink period is 2×`BLINK_MS` cycles, and the first blank starts `BLINK_MS` cycles after state entry.

## Configuration
- `CLOCK_SET_CHIME_EN` defined, chime enabled:
  - Match = ({`Minute`,`Second`}==16'h5959), passed through a 2-flop synchronizer.
  - A rising edge of the synchronized match while in RUN loads a counter.
  - `Beep` is then high for exactly `CHIME_MS` cycles.
  - A retrigger during the pulse is ignored.
  - Leaving RUN mid-pulse lets the pulse finish.
- `CLOCK_SET_CHIME_EN` undefined: `Beep` is constant 0, `Minute`/`Second` are unused, and no chime logic is synthesized.

## Test plan
- Reset with `DB_MS`=20: pulse `ModeKey` for 10 cycles -> `Mode` stays 00. Hold it for 30 cycles -> `Mode`=01 at cycle 23 after press.
- In SET_HR, hold `IncKey` for 3000 cycles -> `AdjHrKey`=1 from debounce until release+22, `AdjMinKey`=0, `HrBlank`=0 throughout.
- Three mode presses -> `Mode` 01, 10, 00. `MinBlank` toggles every 500 cycles only in state 10.
- In SET_MIN, no keys for 10000 cycles -> `Mode` returns to 00. A mode press landing on the expiry cycle -> `Mode`=00 through the press path, with no double transition.
- With `CLOCK_SET_CHIME_EN`, drive `Minute`=8'h59 and `Second`=8'h58→8'h59 in RUN -> `Beep` high for 500 cycles starting 3 cycles after the change. The same stimulus in SET_HR -> `Beep` stays 0.
- Assert `nCR` low mid-debounce and mid-chime -> all outputs 0 immediately, `Mode`=00.
